// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - sequential ALU with start/done handshake and shift-add multiply
`timescale 1ns/1ps

module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       ALU_Control,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Overflow,
    output logic             Illegal
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             ill_q, ill_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] sum, diff, op_result, acc_step;
    logic             slt, op_ovf, op_ill;

    // Single-cycle datapath, evaluated on the live operands at the start edge
    always_comb begin
        sum       = SrcA + SrcB;
        diff      = SrcA - SrcB;
        slt       = $signed(SrcA) < $signed(SrcB);
        op_result = '0;
        op_ovf    = 1'b0;
        op_ill    = 1'b0;
        case (ALU_Control)
            OP_AND: op_result = SrcA & SrcB;
            OP_OR:  op_result = SrcA | SrcB;
            OP_ADD: begin
                op_result = sum;
                op_ovf    = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) &&
                            (sum[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_SUB: begin
                op_result = diff;
                op_ovf    = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) &&
                            (diff[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_SLT: op_result = {{(WIDTH-1){1'b0}}, slt};
            default: op_ill = 1'b1;
        endcase
    end

    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (ALU_Control == OP_MUL) begin
                        mcand_d  = SrcA;
                        mplier_d = SrcB;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        result_d = op_result;
                        zero_d   = (op_result == '0);
                        ovf_d    = op_ovf;
                        ill_d    = op_ill;
                        done_d   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                // Last iteration folds its partial product straight into the result
                if (cnt_q == CNT_LAST) begin
                    result_d = acc_step;
                    zero_d   = (acc_step == '0);
                    ovf_d    = 1'b0;
                    ill_d    = 1'b0;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
            done_q   <= done_d;
        end
    end

    assign busy      = (state_q == S_MUL);
    assign done      = done_q;
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign Overflow  = ovf_q;
    assign Illegal   = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit
`timescale 1ns/1ps

module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  ALU_Control;
    logic [31:0] SrcA, SrcB;
    logic        busy, done, Zero, Overflow, Illegal;
    logic [31:0] ALUResult;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALU_Control(ALU_Control),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
        .ALUResult(ALUResult), .Zero(Zero), .Overflow(Overflow), .Illegal(Illegal)
    );

    typedef struct {
        int          due;
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        il;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        il;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[12];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h cycle=%0d", name, act, want, cyc);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [31:0] r;
        e.ov = 1'b0;
        e.il = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin r = a + b; e.ov = (a[31] == b[31]) && (r[31] != a[31]); end
            3'b100: begin r = a - b; e.ov = (a[31] != b[31]) && (r[31] != a[31]); end
            3'b101: r = a * b;
            3'b110: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin r = 32'd0; e.il = 1'b1; end
        endcase
        e.res = r;
        e.z   = (r == 32'd0);
        e.due = 0;
        return e;
    endfunction

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.due));
                chk("result", ALUResult, e.res);
                chk("zero", 32'(Zero), 32'(e.z));
                chk("overflow", 32'(Overflow), 32'(e.ov));
                chk("illegal", 32'(Illegal), 32'(e.il));
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
        if (sbq.size() != 0 && sbq[0].due < cyc) begin
            chk("missing_done", 32'(done), 32'd1);
            void'(sbq.pop_front());
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input exp_t e_in);
        exp_t e;
        e = e_in;
        e.due = cyc + ((op == 3'b101) ? 33 : 1);
        sbq.push_back(e);
        start = 1'b1;
        ALU_Control = op;
        SrcA = a;
        SrcB = b;
        step();
        start = 1'b0;
    endtask

    task automatic mul_seq(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res, input bit disturb);
        exp_t e;
        e.due = 0; e.res = res; e.z = (res == 32'd0); e.ov = 1'b0; e.il = 1'b0;
        issue(3'b101, a, b, e);
        chk("mul_busy_first", 32'(busy), 32'd1);
        for (int i = 1; i < 32; i++) begin
            if (disturb) begin
                start = 1'($urandom);
                ALU_Control = 3'($urandom);
                SrcA = $urandom;
                SrcB = $urandom;
            end
            step();
            chk("mul_busy", 32'(busy), 32'd1);
        end
        start = 1'b0;
        step();
    endtask

    initial begin
        exp_t e;
        logic [2:0]  op;
        logic [31:0] a, b;

        vt[0]  = '{3'b010, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b1, 1'b0};
        vt[1]  = '{3'b100, 32'd5,        32'd5,        32'h0,        1'b1, 1'b0, 1'b0};
        vt[2]  = '{3'b110, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0, 1'b0};
        vt[3]  = '{3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{3'b001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{3'b011, 32'd3,        32'd4,        32'h0,        1'b1, 1'b0, 1'b1};
        vt[6]  = '{3'b010, 32'd1,        32'd2,        32'h3,        1'b0, 1'b0, 1'b0};
        vt[7]  = '{3'b111, 32'd9,        32'd9,        32'h0,        1'b1, 1'b0, 1'b1};
        vt[8]  = '{3'b100, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vt[9]  = '{3'b110, 32'h1,        32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 1'b0};
        vt[10] = '{3'b010, 32'h80000000, 32'h80000000, 32'h0,        1'b1, 1'b1, 1'b0};
        vt[11] = '{3'b100, 32'h0,        32'h1,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; ALU_Control = 3'b000; SrcA = '0; SrcB = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", ALUResult, 32'd0);
        chk("rst_zero", 32'(Zero), 32'd1);
        chk("rst_ovf", 32'(Overflow), 32'd0);
        chk("rst_ill", 32'(Illegal), 32'd0);
        rst_n = 1'b1;

        // back-to-back single-cycle ops: one done per cycle
        for (int i = 0; i < 12; i++) begin
            e.due = 0; e.res = vt[i].res; e.z = vt[i].z; e.ov = vt[i].ov; e.il = vt[i].il;
            issue(vt[i].op, vt[i].a, vt[i].b, e);
            chk("no_busy_single", 32'(busy), 32'd0);
        end
        repeat (3) step();
        chk("result_held", ALUResult, 32'hFFFFFFFF);

        mul_seq(32'd12345, 32'd6789, 32'd83810205, 1'b1);
        // ADD issued in the MUL done cycle
        issue(3'b010, 32'd10, 32'd20, model(3'b010, 32'd10, 32'd20));
        step();
        mul_seq(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0);
        mul_seq(32'h10000, 32'h10000, 32'd0, 1'b1);
        repeat (2) step();

        // reset in the middle of a multiply
        issue(3'b101, 32'd12345, 32'd6789, model(3'b101, 32'd12345, 32'd6789));
        repeat (9) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", ALUResult, 32'd0);
        chk("midrst_zero", 32'(Zero), 32'd1);
        sbq.delete();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (40) step();
        chk("post_rst_busy", 32'(busy), 32'd0);
        mul_seq(32'd7, 32'd6, 32'd42, 1'b0);

        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a = (i % 5 == 0) ? 32'h7FFFFFFF : $urandom;
            b = (i % 7 == 0) ? 32'h80000000 : $urandom;
            issue(op, a, b, model(op, a, b));
            if (op == 3'b101) repeat (32) step();
        end
        repeat (3) step();
        chk("queue_drained", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
